// File: rtl/shared_port_scheduler.sv
// Packet-level round-robin scheduler sharing one engine port among N requesters.
// Define BURST_LIMIT_EN to force a grant release after MAX_BURST beats.
module shared_port_scheduler #(
  parameter int N         = 4,
  parameter int DW        = 32,
  parameter int MAX_BURST = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  input  logic [N-1:0]    req_last,
  input  logic [N*DW-1:0] req_data,
  output logic [N-1:0]    req_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic            out_last,
  output logic [$clog2(N)-1:0] out_src,
  input  logic            out_ready,
  output logic            busy
);
  localparam int SW = $clog2(N);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t         state_q;
  logic [N-1:0]   prio_q;
  logic [N-1:0]   grant_q;
  logic [CW-1:0]  cnt_q;

  logic [SW-1:0]  prio_idx;
  logic [SW-1:0]  pick_idx;
  logic [N-1:0]   pick_oh;
  logic [SW-1:0]  gidx;
  logic           limit_hit;
  logic           accept;

  // Scan downward in offset so the request closest to prio wins.
  always_comb begin
    prio_idx = '0;
    for (int i = 0; i < N; i++)
      if (prio_q[i]) prio_idx = SW'(i);
    pick_idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req_valid[(int'(prio_idx) + k) % N])
        pick_idx = SW'((int'(prio_idx) + k) % N);
    pick_oh = '0;
    pick_oh[pick_idx] = 1'b1;
  end

  always_comb begin
    gidx = '0;
    for (int i = 0; i < N; i++)
      if (grant_q[i]) gidx = SW'(i);
  end

`ifdef BURST_LIMIT_EN
  assign limit_hit = (cnt_q == CW'(MAX_BURST - 1));
`else
  assign limit_hit = 1'b0;
`endif

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    out_src   = '0;
    req_ready = '0;
    if (state_q == LOCKED) begin
      out_valid       = req_valid[gidx];
      out_data        = req_data[int'(gidx)*DW +: DW];
      out_last        = req_last[gidx] | limit_hit;
      out_src         = gidx;
      req_ready[gidx] = out_ready;
    end
  end

  assign accept = out_valid & out_ready;
  assign busy   = (state_q == LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= N'(1);
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|req_valid) begin
            grant_q <= pick_oh;
            cnt_q   <= '0;
            state_q <= LOCKED;
          end
        end
        LOCKED: begin
          if (accept && cnt_q != '1)
            cnt_q <= cnt_q + CW'(1);
          if (accept && out_last) begin
            prio_q  <= {grant_q[N-2:0], grant_q[N-1]};
            grant_q <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_port_scheduler.sv
// Directed bench for shared_port_scheduler: vector table plus
// hand-written multi-cycle sequences.
module tb_shared_port_scheduler;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_last;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic [SW-1:0]   out_src;
  logic            out_ready;
  logic            busy;

  int passed = 0;
  int total  = 0;

  shared_port_scheduler #(.N(N), .DW(DW), .MAX_BURST(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_src(out_src),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] v;
    logic [3:0] l;
    logic       rdy;
    logic       ov;
    logic [1:0] src;
    logic       ol;
    logic [3:0] rr;
    logic       bz;
  } vec_t;

  typedef struct {
    logic [1:0]    src;
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  vec_t tbl[24];

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic logic [DW-1:0] tdata(input int i);
    return 32'hC0DE_0000 | DW'(i);
  endfunction

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l,
                              input logic rdy, input logic ov,
                              input logic [1:0] src, input logic ol,
                              input logic [3:0] rr, input logic bz);
    vec_t t;
    t.v = v; t.l = l; t.rdy = rdy; t.ov = ov;
    t.src = src; t.ol = ol; t.rr = rr; t.bz = bz;
    return t;
  endfunction

  function automatic logic [63:0] outs();
    return 64'({out_valid, out_src, out_last, req_ready, busy, out_data});
  endfunction

  task automatic run_table();
    logic [63:0] exp;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = tdata(i);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      req_valid = tbl[i].v;
      req_last  = tbl[i].l;
      out_ready = tbl[i].rdy;
      #1;
      exp = 64'({tbl[i].ov, tbl[i].src, tbl[i].ol, tbl[i].rr, tbl[i].bz,
                 tbl[i].bz ? tdata(int'(tbl[i].src)) : 32'h0});
      check($sformatf("vec%0d", i), outs(), exp);
    end
  endtask

  task automatic gap_seq();
    logic [DW-1:0] got_q[$];
    int beat = 0;
    int gapc = 0;
    bit locked = 0, done = 0, drop = 0, gap_seen = 0, gap_bad = 0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      out_ready = (cyc % 2 == 0);
      req_valid = '0;
      req_last  = '0;
      if (beat == 2 && gapc < 2) gapc++;
      else begin
        req_valid[3] = 1'b1;
        req_last[3]  = (beat == 5);
      end
      req_data[3*DW +: DW] = 32'h300 + DW'(beat);
      #1;
      if (busy) locked = 1;
      else if (locked) drop = 1;
      if (!req_valid[3] && locked) begin
        gap_seen = 1;
        if (out_valid) gap_bad = 1;
      end
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        if (out_last) done = 1;
      end
      if (req_valid[3] && req_ready[3]) beat++;
    end
    check("gap_done", 64'(done), 64'd1);
    check("gap_busy_held", 64'(drop), 64'd0);
    check("gap_seen", 64'(gap_seen), 64'd1);
    check("gap_valid_low", 64'(gap_bad), 64'd0);
    check("gap_count", 64'(got_q.size()), 64'd6);
    for (int i = 0; i < got_q.size() && i < 6; i++)
      check($sformatf("gap_beat%0d", i), 64'(got_q[i]), 64'(32'h300 + i));
    @(negedge clk);
    req_valid = '0;
    req_last  = '0;
    #1;
    check("gap_release", 64'(busy), 64'd0);
  endtask

  task automatic reset_seq();
    @(negedge clk);
    req_valid = 4'b0100;
    req_last  = '0;
    req_data[2*DW +: DW] = 32'h200;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("rst_pre_lock", 64'({busy, out_valid, out_src}), 64'({2'b11, 2'd2}));
    rst = 1'b1;
    #1;
    check("rst_async_zero", outs(), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b0110;
    req_last  = 4'b0110;
    #1;
    check("rst_idle", 64'(busy), 64'd0);
    @(negedge clk);
    #1;
    check("rst_grant1", 64'({busy, out_valid, out_src}), 64'({2'b11, 2'd1}));
    @(negedge clk);
    req_valid = '0;
    req_last  = '0;
  endtask

  task automatic burst_seq();
    beat_t got_q[$];
    beat_t exp_q[$];
    beat_t b;
    int b3 = 0, b0 = 0;
`ifdef BURST_LIMIT_EN
    for (int i = 0; i < 8; i++) begin
      b.src = 2'd3; b.d = 32'h300 + i; b.l = (i == 7); exp_q.push_back(b);
    end
    for (int i = 0; i < 2; i++) begin
      b.src = 2'd0; b.d = 32'h100 + i; b.l = (i == 1); exp_q.push_back(b);
    end
    for (int i = 8; i < 12; i++) begin
      b.src = 2'd3; b.d = 32'h300 + i; b.l = (i == 11); exp_q.push_back(b);
    end
`else
    for (int i = 0; i < 12; i++) begin
      b.src = 2'd3; b.d = 32'h300 + i; b.l = (i == 11); exp_q.push_back(b);
    end
    for (int i = 0; i < 2; i++) begin
      b.src = 2'd0; b.d = 32'h100 + i; b.l = (i == 1); exp_q.push_back(b);
    end
`endif
    for (int cyc = 0; cyc < 80 && !(b3 == 12 && b0 == 2); cyc++) begin
      @(negedge clk);
      out_ready = 1'b1;
      req_valid = '0;
      req_last  = '0;
      if (b3 < 12) begin
        req_valid[3] = 1'b1;
        req_last[3]  = (b3 == 11);
        req_data[3*DW +: DW] = 32'h300 + DW'(b3);
      end
      if (cyc >= 2 && b0 < 2) begin
        req_valid[0] = 1'b1;
        req_last[0]  = (b0 == 1);
        req_data[0 +: DW] = 32'h100 + DW'(b0);
      end
      #1;
      if (out_valid && out_ready) begin
        b.src = out_src; b.d = out_data; b.l = out_last;
        got_q.push_back(b);
      end
      if (req_valid[3] && req_ready[3]) b3++;
      if (req_valid[0] && req_ready[0]) b0++;
    end
    check("burst_done", 64'({b3 == 12, b0 == 2}), 64'b11);
    check("burst_count", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("burst_beat%0d", i),
            64'({got_q[i].src, got_q[i].l, got_q[i].d}),
            64'({exp_q[i].src, exp_q[i].l, exp_q[i].d}));
    @(negedge clk);
    req_valid = '0;
    req_last  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mk(4'b1111, 4'b1111, 1, 0, 0, 0, 4'b0000, 0);
    tbl[1]  = mk(4'b1111, 4'b1111, 1, 1, 0, 1, 4'b0001, 1);
    tbl[2]  = mk(4'b1111, 4'b1111, 1, 0, 0, 0, 4'b0000, 0);
    tbl[3]  = mk(4'b1111, 4'b1111, 1, 1, 1, 1, 4'b0010, 1);
    tbl[4]  = mk(4'b1111, 4'b1111, 1, 0, 0, 0, 4'b0000, 0);
    tbl[5]  = mk(4'b1111, 4'b1111, 1, 1, 2, 1, 4'b0100, 1);
    tbl[6]  = mk(4'b1111, 4'b1111, 1, 0, 0, 0, 4'b0000, 0);
    tbl[7]  = mk(4'b1111, 4'b1111, 1, 1, 3, 1, 4'b1000, 1);
    tbl[8]  = mk(4'b0011, 4'b0010, 1, 0, 0, 0, 4'b0000, 0);
    tbl[9]  = mk(4'b0011, 4'b0010, 1, 1, 0, 0, 4'b0001, 1);
    tbl[10] = mk(4'b0011, 4'b0010, 1, 1, 0, 0, 4'b0001, 1);
    tbl[11] = mk(4'b0011, 4'b0010, 1, 1, 0, 0, 4'b0001, 1);
    tbl[12] = mk(4'b0011, 4'b0010, 1, 1, 0, 0, 4'b0001, 1);
    tbl[13] = mk(4'b0011, 4'b0011, 1, 1, 0, 1, 4'b0001, 1);
    tbl[14] = mk(4'b0011, 4'b0011, 1, 0, 0, 0, 4'b0000, 0);
    tbl[15] = mk(4'b0010, 4'b0010, 1, 1, 1, 1, 4'b0010, 1);
    tbl[16] = mk(4'b0010, 4'b0010, 1, 0, 0, 0, 4'b0000, 0);
    tbl[17] = mk(4'b0010, 4'b0010, 1, 1, 1, 1, 4'b0010, 1);
    tbl[18] = mk(4'b0101, 4'b0101, 1, 0, 0, 0, 4'b0000, 0);
    tbl[19] = mk(4'b0101, 4'b0101, 1, 1, 2, 1, 4'b0100, 1);
    tbl[20] = mk(4'b1001, 4'b1001, 0, 0, 0, 0, 4'b0000, 0);
    tbl[21] = mk(4'b1001, 4'b1001, 0, 1, 3, 1, 4'b0000, 1);
    tbl[22] = mk(4'b1001, 4'b1001, 1, 1, 3, 1, 4'b1000, 1);
    tbl[23] = mk(4'b0000, 4'b0000, 1, 0, 0, 0, 4'b0000, 0);

    rst       = 1'b1;
    req_valid = 4'b1111;
    req_last  = '0;
    req_data  = '1;
    out_ready = 1'b1;
    #1;
    check("reset_outputs", outs(), 64'd0);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;

    run_table();
    gap_seq();
    reset_seq();
    burst_seq();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
